xgmii_tx_scheduler: RTL and testbench

- Frame scheduler in front of the 10GBASE-R TX 32-bit encoder.
- Accepts a 32-bit byte-keep frame stream and emits XGMII 32-bit words (data/control) with the enable that drives the encoder input.
- Produces only encoder-legal sequences: start on lane 0 of the first half of a 64-bit block, terminate patterns FD/07, IPG enforcement.
- Advances only on gearbox-permitted cycles.

---
 rtl/xgmii_tx_scheduler.sv | 233 +++++++++++++++++++++++
 tb/tb_xgmii_tx_scheduler.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_tx_scheduler.sv
// -----------------------------------------------------------------------------
// xgmii_tx_scheduler
//
// Frame scheduler in front of the 10GBASE-R 32-bit TX encoder. Turns a 32-bit
// byte-keep frame stream into XGMII 32-bit data/control words that the encoder
// accepts: every frame starts on lane 0 of the first half of a 64-bit block,
// terminates with FD followed by 07 fill, and is followed by at least
// IPG_BYTES of gap (terminate-word control bytes included). Everything advances
// only on cycles where the gearbox permits (i_tx_adv).
//
// Parameters
//   IPG_BYTES  minimum inter-packet gap in bytes (4..64)
//   CNT_W      width of o_frame_cnt
//
// Ports
//   i_clk        clock
//   i_rst        asynchronous active-high reset
//   i_tx_enable  1 = frames may start; 0 = idles only (a running frame completes)
//   i_tx_adv     gearbox advance permit, low on stall cycles
//   i_s_data     frame bytes, lane 0 = [7:0]
//   i_s_keep     valid lanes of the beat (1111 on non-last beats)
//   i_s_last     last beat of the frame
//   i_s_valid    beat valid
//   o_s_ready    beat accepted when i_s_valid & o_s_ready (combinational)
//   o_xgmii_d    XGMII data word
//   o_xgmii_c    XGMII per-lane control flags
//   o_xgmii_en   word valid, drives encoder din_en
//   o_underrun   one-cycle pulse alongside the terminate word of an underrun
//   o_frame_cnt  frames completed without underrun (wraps)
//
// State | meaning
// ------+------------------------------------------------------------------
// IDLE  | emitting idles, counting down the gap, waiting for an aligned start
// PRE   | start word sent, emitting the second preamble/SFD word
// DATA  | forwarding frame beats
// TERM  | full last beat sent, emitting the pure terminate word
// DROP  | frame truncated by underrun, discarding beats up to s_last
// -----------------------------------------------------------------------------
module xgmii_tx_scheduler #(
  parameter int IPG_BYTES = 12,
  parameter int CNT_W     = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tx_enable,
  input  logic             i_tx_adv,
  input  logic [31:0]      i_s_data,
  input  logic [3:0]       i_s_keep,
  input  logic             i_s_last,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  output logic [31:0]      o_xgmii_d,
  output logic [3:0]       o_xgmii_c,
  output logic             o_xgmii_en,
  output logic             o_underrun,
  output logic [CNT_W-1:0] o_frame_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_TERM,
    ST_DROP
  } state_t;

  localparam logic [31:0] IDLE_WORD  = 32'h0707_0707;
  localparam logic [31:0] START_WORD = 32'h5555_55FB;
  localparam logic [31:0] PRE_WORD   = 32'hD555_5555;
  localparam logic [31:0] TERM_WORD  = 32'h0707_07FD;

  // Gap in idle words after a terminate word holding k data bytes:
  // ceil((IPG_BYTES - (4 - k)) / 4) = (IPG_BYTES + k - 1) / 4. IPG_BYTES >= 4
  // keeps the numerator non-negative, so no clamp is needed.
  localparam int IPG_W = 7;
  localparam logic [IPG_W-1:0] IPG_K0 = IPG_W'((IPG_BYTES - 1) / 4);
  localparam logic [IPG_W-1:0] IPG_K1 = IPG_W'((IPG_BYTES + 0) / 4);
  localparam logic [IPG_W-1:0] IPG_K2 = IPG_W'((IPG_BYTES + 1) / 4);
  localparam logic [IPG_W-1:0] IPG_K3 = IPG_W'((IPG_BYTES + 2) / 4);

  state_t           r_state;
  logic             r_pos;
  logic [IPG_W-1:0] r_ipg_cnt;
  logic [31:0]      r_xgmii_d;
  logic [3:0]       r_xgmii_c;
  logic             r_xgmii_en;
  logic             r_underrun;
  logic [CNT_W-1:0] r_frame_cnt;

  state_t           w_state_nxt;
  logic [31:0]      w_d_nxt;
  logic [3:0]       w_c_nxt;
  logic [IPG_W-1:0] w_ipg_nxt;
  logic             w_underrun_nxt;
  logic             w_frame_done;
  logic             w_s_ready;
  logic             w_drop_exit;

  // Next-state and next-word decode. Idle words and a saturating gap
  // decrement are the defaults; each state overrides what it emits.
  always_comb begin
    w_state_nxt    = r_state;
    w_d_nxt        = IDLE_WORD;
    w_c_nxt        = 4'hF;
    w_ipg_nxt      = (r_ipg_cnt != '0) ? r_ipg_cnt - IPG_W'(1) : '0;
    w_underrun_nxt = 1'b0;
    w_frame_done   = 1'b0;
    w_s_ready      = 1'b0;
    w_drop_exit    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Start only on the first half of a block with the gap fully spent;
        // at pos 1 the idle emitted here is the alignment idle.
        if (!r_pos && (r_ipg_cnt == '0) && i_tx_enable && i_s_valid) begin
          w_d_nxt     = START_WORD;
          w_c_nxt     = 4'b0001;
          w_state_nxt = ST_PRE;
        end
      end

      ST_PRE: begin
        w_d_nxt     = PRE_WORD;
        w_c_nxt     = 4'h0;
        w_state_nxt = ST_DATA;
      end

      ST_DATA: begin
        w_s_ready = i_tx_adv;
        if (i_s_valid) begin
          w_d_nxt = i_s_data;
          w_c_nxt = 4'h0;
          if (i_s_last) begin
            case (i_s_keep)
              4'b0001: begin
                w_d_nxt      = {16'h0707, 8'hFD, i_s_data[7:0]};
                w_c_nxt      = 4'b1110;
                w_ipg_nxt    = IPG_K1;
                w_frame_done = 1'b1;
                w_state_nxt  = ST_IDLE;
              end
              4'b0011: begin
                w_d_nxt      = {8'h07, 8'hFD, i_s_data[15:0]};
                w_c_nxt      = 4'b1100;
                w_ipg_nxt    = IPG_K2;
                w_frame_done = 1'b1;
                w_state_nxt  = ST_IDLE;
              end
              4'b0111: begin
                w_d_nxt      = {8'hFD, i_s_data[23:0]};
                w_c_nxt      = 4'b1000;
                w_ipg_nxt    = IPG_K3;
                w_frame_done = 1'b1;
                w_state_nxt  = ST_IDLE;
              end
              // Full keep and any non-contiguous pattern: whole word is data,
              // the terminate goes out in its own word.
              default: w_state_nxt = ST_TERM;
            endcase
          end
        end else begin
          // Source ran dry mid-frame: close the frame on the wire right away.
          w_d_nxt        = TERM_WORD;
          w_c_nxt        = 4'hF;
          w_underrun_nxt = 1'b1;
          w_ipg_nxt      = IPG_K0;
          w_state_nxt    = ST_DROP;
        end
      end

      ST_TERM: begin
        w_d_nxt      = TERM_WORD;
        w_c_nxt      = 4'hF;
        w_ipg_nxt    = IPG_K0;
        w_frame_done = 1'b1;
        w_state_nxt  = ST_IDLE;
      end

      ST_DROP: begin
        w_s_ready = 1'b1;
        if (i_s_valid && i_s_last) begin
          w_drop_exit = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // DROP accepts beats even on stall cycles, so a consumed s_last must take
  // the FSM out of DROP on that cycle too; otherwise the next frame's beats
  // would be swallowed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else if (i_tx_adv || w_drop_exit) begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pos       <= 1'b0;
      r_ipg_cnt   <= '0;
      r_xgmii_d   <= IDLE_WORD;
      r_xgmii_c   <= 4'hF;
      r_xgmii_en  <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_xgmii_en <= i_tx_adv;
      r_underrun <= i_tx_adv & w_underrun_nxt;
      if (i_tx_adv) begin
        r_pos     <= ~r_pos;
        r_ipg_cnt <= w_ipg_nxt;
        r_xgmii_d <= w_d_nxt;
        r_xgmii_c <= w_c_nxt;
        if (w_frame_done) begin
          r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_s_ready   = w_s_ready;
  assign o_xgmii_d   = r_xgmii_d;
  assign o_xgmii_c   = r_xgmii_c;
  assign o_xgmii_en  = r_xgmii_en;
  assign o_underrun  = r_underrun;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_xgmii_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_xgmii_tx_scheduler
//
// Drives frames (random data, lengths, last-beat keep and gearbox stalls) and
// compares the stream of advanced XGMII words against a reference built from
// the framing rules: words are numbered from reset, so a word's block half is
// its index parity; a frame starts at the first even index at or after the
// end of the previous gap.
// -----------------------------------------------------------------------------
module tb_xgmii_tx_scheduler;
  localparam int IPG_BYTES = 12;
  localparam int CNT_W     = 32;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        gap;
  } beat_t;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  c;
    logic        u;
  } word_t;

  localparam word_t IDLE_W = '{d: 32'h07070707, c: 4'hF, u: 1'b0};

  logic             clk = 1'b0;
  logic             rst;
  logic             tx_enable, tx_adv;
  logic [31:0]      s_data;
  logic [3:0]       s_keep;
  logic             s_last, s_valid, s_ready;
  logic [31:0]      xgmii_d;
  logic [3:0]       xgmii_c;
  logic             xgmii_en, underrun;
  logic [CNT_W-1:0] frame_cnt;

  beat_t stim_q[$];
  word_t exp_q[$];
  word_t cap_q[$];
  int    start_min;
  int    exp_frames;
  bit    cap_on;
  int    errors = 0;
  int    checks = 0;

  logic        obs_ready [256];
  logic        obs_en    [256];
  logic [31:0] obs_d     [256];

  xgmii_tx_scheduler #(.IPG_BYTES(IPG_BYTES), .CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_tx_enable (tx_enable),
    .i_tx_adv    (tx_adv),
    .i_s_data    (s_data),
    .i_s_keep    (s_keep),
    .i_s_last    (s_last),
    .i_s_valid   (s_valid),
    .o_s_ready   (s_ready),
    .o_xgmii_d   (xgmii_d),
    .o_xgmii_c   (xgmii_c),
    .o_xgmii_en  (xgmii_en),
    .o_underrun  (underrun),
    .o_frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cap_on && xgmii_en) cap_q.push_back({xgmii_d, xgmii_c, underrun});
  end

  // ---------------- reference model ----------------
  function automatic int ipg_words(int k);
    int gap;
    gap = IPG_BYTES - (4 - k);
    if (gap <= 0) return 0;
    return (gap + 3) / 4;
  endfunction

  function automatic void push_w(logic [31:0] d, logic [3:0] c, logic u);
    word_t w;
    w.d = d; w.c = c; w.u = u;
    exp_q.push_back(w);
  endfunction

  function automatic void align_start();
    while (exp_q.size() < start_min || (exp_q.size() % 2) != 0)
      push_w(32'h07070707, 4'hF, 1'b0);
    push_w(32'h555555FB, 4'b0001, 1'b0);
    push_w(32'hD5555555, 4'h0, 1'b0);
  endfunction

  function automatic void gen_frame(int nbeats, logic [3:0] last_keep,
                                    bit fix_last, logic [31:0] last_d);
    beat_t       b;
    logic [31:0] d, t;
    logic [3:0]  c;
    int          k;
    align_start();
    d = '0;
    for (int i = 0; i < nbeats; i++) begin
      d = (fix_last && i == nbeats - 1) ? last_d : $urandom;
      b.data = d;
      b.last = (i == nbeats - 1);
      b.keep = b.last ? last_keep : 4'hF;
      b.gap  = 1'b0;
      stim_q.push_back(b);
      if (!b.last) push_w(d, 4'h0, 1'b0);
    end
    case (last_keep)
      4'b0001: k = 1;
      4'b0011: k = 2;
      4'b0111: k = 3;
      default: k = 0;
    endcase
    if (k == 0) begin
      push_w(d, 4'h0, 1'b0);
      push_w(32'h070707FD, 4'hF, 1'b0);
    end else begin
      t = '0; c = '0;
      for (int l = 0; l < 4; l++) begin
        if (l < k)       t[l*8 +: 8] = d[l*8 +: 8];
        else if (l == k) t[l*8 +: 8] = 8'hFD;
        else             t[l*8 +: 8] = 8'h07;
        c[l] = (l >= k);
      end
      push_w(t, c, 1'b0);
    end
    start_min = exp_q.size() + ipg_words(k);
    exp_frames++;
  endfunction

  // Frame whose source stalls before beat 'good'; with the source then
  // offering one beat per advance, the rest drains one beat per word.
  function automatic void gen_truncated(int nbeats, int good);
    beat_t b;
    int    drain_end;
    align_start();
    for (int i = 0; i < nbeats; i++) begin
      b.data = $urandom;
      b.last = (i == nbeats - 1);
      b.keep = 4'hF;
      b.gap  = (i == good);
      stim_q.push_back(b);
      if (i < good) push_w(b.data, 4'h0, 1'b0);
    end
    push_w(32'h070707FD, 4'hF, 1'b1);
    drain_end = exp_q.size() + (nbeats - good);
    start_min = exp_q.size() + ipg_words(0);
    if (drain_end > start_min) start_min = drain_end;
  endfunction

  function automatic void gen_stim_only(int nbeats);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.data = $urandom; b.keep = 4'hF; b.last = (i == nbeats - 1); b.gap = 1'b0;
      stim_q.push_back(b);
    end
  endfunction

  // ---------------- stimulus ----------------
  task automatic do_reset();
    cap_on = 1'b0;
    rst = 1'b1; tx_adv = 1'b1; tx_enable = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; s_keep = 4'h0; s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    stim_q.delete(); exp_q.delete(); cap_q.delete();
    start_min = 0; exp_frames = 0;
    rst = 1'b0; cap_on = 1'b1;
  endtask

  task automatic run_stream(int adv_pct, int stall_at, int en_off_at,
                            int max_cycles, output int left);
    bit    acc;
    int    cyc, tail;
    beat_t hb;
    acc = 1'b0; cyc = 0; tail = 0;
    tx_enable = 1'b1;
    while (cyc < max_cycles && tail < 40) begin
      if (acc) void'(stim_q.pop_front());
      if (stim_q.size() == 0) tail++;
      tx_adv = (int'($urandom_range(99)) < adv_pct) && (cyc != stall_at);
      if (en_off_at >= 0 && cyc >= en_off_at) tx_enable = 1'b0;
      if (stim_q.size() > 0 && stim_q[0].gap) begin
        hb = stim_q[0]; hb.gap = 1'b0; stim_q[0] = hb;
        s_valid = 1'b0; s_data = $urandom; s_last = 1'b0; s_keep = 4'h0;
      end else if (stim_q.size() > 0) begin
        s_valid = 1'b1; s_data = stim_q[0].data;
        s_keep = stim_q[0].keep; s_last = stim_q[0].last;
      end else begin
        s_valid = 1'b0; s_data = $urandom; s_last = 1'b0; s_keep = 4'h0;
      end
      @(negedge clk);
      acc = s_valid && s_ready;
      if (cyc < 256) begin
        obs_ready[cyc] = s_ready; obs_en[cyc] = xgmii_en; obs_d[cyc] = xgmii_d;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (acc) void'(stim_q.pop_front());
    s_valid = 1'b0;
    left = stim_q.size();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; tx_enable = 1'b1; tx_adv = 1'b1; s_valid = 1'b0;
    s_last = 1'b0; s_keep = 4'h0; s_data = '0; cap_on = 1'b0;
    #1;
    checks++;
    if (xgmii_d !== 32'h07070707 || xgmii_c !== 4'hF || xgmii_en !== 1'b0 ||
        s_ready !== 1'b0 || underrun !== 1'b0 || frame_cnt !== '0) begin
      errors++;
      $display("FAIL reset_values: got d=%h c=%h en=%b rdy=%b u=%b cnt=%0d required 07070707 f 0 0 0 0",
               xgmii_d, xgmii_c, xgmii_en, s_ready, underrun, frame_cnt);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (xgmii_d !== 32'h07070707 || xgmii_c !== 4'hF || xgmii_en !== 1'b1 || frame_cnt !== '0) begin
      errors++;
      $display("FAIL reset_idle: got d=%h c=%h en=%b cnt=%0d required 07070707 f 1 0",
               xgmii_d, xgmii_c, xgmii_en, frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int left;
    do_reset();
    gen_frame(3, 4'hF, 1'b0, '0);
    gen_frame(2, 4'hF, 1'b0, '0);
    run_stream(100, -1, -1, 300, left);
    checks++;
    if (left !== 0) begin errors++; $display("FAIL b2b_drain: got %0d beats left required 0", left); end
    for (int i = 0; i < exp_q.size() + 4; i++) begin
      word_t e, g;
      e = (i < exp_q.size()) ? exp_q[i] : IDLE_W;
      g = (i < cap_q.size()) ? cap_q[i] : 'x;
      checks++;
      if (g !== e) begin errors++; $display("FAIL b2b word %0d: got %h required %h", i, g, e); end
    end
    checks++;
    if (cap_q.size() <= 8 || cap_q[8].d !== 32'h555555FB) begin
      errors++; $display("FAIL b2b_second_start: second start word not at index 8");
    end
    checks++;
    if (frame_cnt !== CNT_W'(2)) begin errors++; $display("FAIL b2b_cnt: got %0d required 2", frame_cnt); end
  endtask

  task automatic test_partial_term();
    int left;
    do_reset();
    gen_frame(1, 4'b0011, 1'b1, 32'hAABBCCDD);
    gen_frame(2, 4'b0001, 1'b0, '0);
    gen_frame(3, 4'b0111, 1'b0, '0);
    gen_frame(2, 4'b0101, 1'b0, '0);
    gen_frame(1, 4'hF, 1'b0, '0);
    run_stream(100, -1, -1, 300, left);
    checks++;
    if (left !== 0) begin errors++; $display("FAIL partial_drain: got %0d beats left required 0", left); end
    checks++;
    if (cap_q.size() <= 2 || cap_q[2] !== {32'h07FDCCDD, 4'b1100, 1'b0}) begin
      errors++; $display("FAIL partial_k2_word: word 2 is not 07FDCCDD/1100");
    end
    for (int i = 0; i < exp_q.size() + 4; i++) begin
      word_t e, g;
      e = (i < exp_q.size()) ? exp_q[i] : IDLE_W;
      g = (i < cap_q.size()) ? cap_q[i] : 'x;
      checks++;
      if (g !== e) begin errors++; $display("FAIL partial word %0d: got %h required %h", i, g, e); end
    end
    checks++;
    if (frame_cnt !== CNT_W'(exp_frames)) begin
      errors++; $display("FAIL partial_cnt: got %0d required %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_stall();
    int left;
    do_reset();
    gen_frame(4, 4'hF, 1'b0, '0);
    gen_frame(1, 4'b0111, 1'b0, '0);
    run_stream(100, 4, -1, 300, left);
    checks++;
    if (obs_ready[4] !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b required 0", obs_ready[4]); end
    checks++;
    if (obs_en[4] !== 1'b1 || obs_en[5] !== 1'b0) begin
      errors++; $display("FAIL stall_en: got %b%b required 10", obs_en[4], obs_en[5]);
    end
    checks++;
    if (obs_d[5] !== exp_q[3].d) begin
      errors++; $display("FAIL stall_hold: got %h required %h", obs_d[5], exp_q[3].d);
    end
    for (int i = 0; i < exp_q.size() + 4; i++) begin
      word_t e, g;
      e = (i < exp_q.size()) ? exp_q[i] : IDLE_W;
      g = (i < cap_q.size()) ? cap_q[i] : 'x;
      checks++;
      if (g !== e) begin errors++; $display("FAIL stall word %0d: got %h required %h", i, g, e); end
    end
    checks++;
    if (left !== 0) begin errors++; $display("FAIL stall_drain: got %0d beats left required 0", left); end
  endtask

  task automatic test_underrun();
    int left;
    do_reset();
    gen_truncated(4, 1);
    gen_frame(2, 4'hF, 1'b0, '0);
    run_stream(100, -1, -1, 300, left);
    checks++;
    if (left !== 0) begin errors++; $display("FAIL underrun_drain: got %0d beats left required 0", left); end
    checks++;
    if (cap_q.size() <= 3 || cap_q[3] !== {32'h070707FD, 4'hF, 1'b1}) begin
      errors++; $display("FAIL underrun_term: word 3 is not 070707FD/F with underrun");
    end
    for (int i = 0; i < exp_q.size() + 4; i++) begin
      word_t e, g;
      e = (i < exp_q.size()) ? exp_q[i] : IDLE_W;
      g = (i < cap_q.size()) ? cap_q[i] : 'x;
      checks++;
      if (g !== e) begin errors++; $display("FAIL underrun word %0d: got %h required %h", i, g, e); end
    end
    checks++;
    if (frame_cnt !== CNT_W'(1)) begin errors++; $display("FAIL underrun_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_disable();
    int left;
    do_reset();
    gen_frame(5, 4'hF, 1'b0, '0);
    gen_stim_only(2);
    run_stream(100, -1, 4, 60, left);
    checks++;
    if (left !== 2) begin errors++; $display("FAIL disable_hold: got %0d beats left required 2", left); end
    for (int i = 0; i < exp_q.size() + 4; i++) begin
      word_t e, g;
      e = (i < exp_q.size()) ? exp_q[i] : IDLE_W;
      g = (i < cap_q.size()) ? cap_q[i] : 'x;
      checks++;
      if (g !== e) begin errors++; $display("FAIL disable word %0d: got %h required %h", i, g, e); end
    end
    checks++;
    if (frame_cnt !== CNT_W'(1)) begin errors++; $display("FAIL disable_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_reset_mid();
    int left;
    do_reset();
    gen_frame(6, 4'hF, 1'b0, '0);
    run_stream(100, -1, -1, 5, left);
    checks++;
    if (xgmii_en !== 1'b1 || xgmii_d !== exp_q[4].d) begin
      errors++; $display("FAIL rstmid_pre: got en=%b d=%h required 1 %h", xgmii_en, xgmii_d, exp_q[4].d);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (xgmii_d !== 32'h07070707 || xgmii_c !== 4'hF || xgmii_en !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: got d=%h c=%h en=%b rdy=%b required 07070707 f 0 0",
               xgmii_d, xgmii_c, xgmii_en, s_ready);
    end
    do_reset();
    gen_frame(2, 4'b0011, 1'b0, '0);
    gen_frame(1, 4'hF, 1'b0, '0);
    run_stream(100, -1, -1, 300, left);
    for (int i = 0; i < exp_q.size() + 4; i++) begin
      word_t e, g;
      e = (i < exp_q.size()) ? exp_q[i] : IDLE_W;
      g = (i < cap_q.size()) ? cap_q[i] : 'x;
      checks++;
      if (g !== e) begin errors++; $display("FAIL rstmid word %0d: got %h required %h", i, g, e); end
    end
    checks++;
    if (frame_cnt !== CNT_W'(2)) begin errors++; $display("FAIL rstmid_cnt: got %0d required 2", frame_cnt); end
  endtask

  task automatic test_random();
    int left;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int f = 0; f < 10; f++)
        gen_frame($urandom_range(1, 6), 4'($urandom_range(0, 15)), 1'b0, '0);
      run_stream(60 + 15 * r, -1, -1, 3000, left);
      checks++;
      if (left !== 0) begin errors++; $display("FAIL random_drain %0d: got %0d beats left required 0", r, left); end
      for (int i = 0; i < exp_q.size() + 4; i++) begin
        word_t e, g;
        e = (i < exp_q.size()) ? exp_q[i] : IDLE_W;
        g = (i < cap_q.size()) ? cap_q[i] : 'x;
        checks++;
        if (g !== e) begin errors++; $display("FAIL random%0d word %0d: got %h required %h", r, i, g, e); end
      end
      checks++;
      if (frame_cnt !== CNT_W'(exp_frames)) begin
        errors++; $display("FAIL random_cnt %0d: got %0d required %0d", r, frame_cnt, exp_frames);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_back_to_back();
    test_partial_term();
    test_stall();
    test_underrun();
    test_disable();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
